ddr_cmd_initiator: RTL and testbench



---
 rtl/ddr_pkg.sv | 79 +++++++
 rtl/ddr_wait_timer.sv | 28 ++
 rtl/ddr_cmd_initiator.sv | 185 ++++++++++++++++++
 tb/tb_ddr_cmd_initiator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared types and helpers for the DDR command initiator: command/state enums,
// the request address layout and the command-to-pin encoding.
package ddr_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_WR,
    CMD_RD,
    CMD_PRE
  } cmd_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PRE,
    ST_PRE_WAIT,
    ST_ACT,
    ST_RCD_WAIT,
    ST_ACCESS,
    ST_RD_WAIT
  } init_state_e;

  typedef struct packed {
    logic       bank_grp;
    logic [1:0] bank_no;
    logic [2:0] row;
    logic [2:0] col;
  } ddr_addr_t;

  typedef struct packed {
    logic       bank_grp;
    logic [1:0] bank_no;
    logic [2:0] row;
  } ddr_row_t;

  typedef struct packed {
    logic act;
    logic cs;
    logic ras;
    logic cas;
    logic rwb;
    logic auto_pre;
  } cmd_pins_t;

  // Column commands carry the page policy on auto_pre; PRE reuses auto_pre as its strobe.
  function automatic cmd_pins_t encode_cmd(cmd_e c, logic closed_page);
    cmd_pins_t p;
    p = '0;
    case (c)
      CMD_ACT: begin
        p.act = 1'b1;
        p.ras = 1'b1;
      end
      CMD_WR: begin
        p.act      = 1'b1;
        p.cs       = 1'b1;
        p.cas      = 1'b1;
        p.rwb      = 1'b1;
        p.auto_pre = closed_page;
      end
      CMD_RD: begin
        p.act      = 1'b1;
        p.cs       = 1'b1;
        p.cas      = 1'b1;
        p.auto_pre = closed_page;
      end
      CMD_PRE: p.auto_pre = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

  // Wait states never last less than one cycle.
  function automatic int clamp1(int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/ddr_wait_timer.sv
// Loadable down-counter: start loads a cycle count, done is high in the last cycle
// of the wait. The reset value lets the counter time the post-reset INIT period.
module ddr_wait_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_CNT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_CNT;
    end else if (start) begin
      cnt <= (load_val == '0) ? '0 : load_val - W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ddr_cmd_initiator.sv
// Host-side ACT/RD/WR/PRE initiator for the behavioural DDR bank model; tracks one
// open row, precharges/activates only on a miss and returns read data on rsp_valid.
module ddr_cmd_initiator
  import ddr_pkg::*;
#(
  parameter int T_INIT    = 4,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2,
  parameter int T_CL      = 1,
  parameter int OPEN_PAGE = 1
) (
  input  logic        clk_t,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rwb,
  input  logic [8:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        cke,
  output logic        cs,
  output logic        act,
  output logic        ras,
  output logic        cas,
  output logic        rwb,
  output logic        auto_pre,
  output logic        bank_grp,
  output logic [1:0]  bank_no,
  output logic [2:0]  row_address,
  output logic [2:0]  col_address,
  output logic [15:0] dq_out,
  input  logic [15:0] dq_in
);

  localparam logic [7:0] INIT_LD = 8'(clamp1(T_INIT) - 1);
  localparam logic [7:0] RP_LD   = 8'(clamp1(T_RP - 1));
  localparam logic [7:0] RCD_LD  = 8'(clamp1(T_RCD - 1));
  localparam logic [7:0] CL_LD   = 8'(clamp1(T_CL));
  localparam logic       CLOSED_PAGE = (OPEN_PAGE == 0);

  init_state_e state, nxt;
  cmd_e        cmd;
  cmd_pins_t   pins;
  ddr_addr_t   a_in, req_q;
  ddr_row_t    open_q;
  logic        rwb_q, row_open, accept, hit;
  logic [15:0] wdata_q;
  logic        tmr_start, tmr_done;
  logic [7:0]  tmr_load;

  assign a_in      = ddr_addr_t'(req_addr);
  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign hit       = row_open && (open_q == {a_in.bank_grp, a_in.bank_no, a_in.row});

  ddr_wait_timer #(.W(8), .RST_CNT(INIT_LD)) u_timer (
    .clk      (clk_t),
    .rst_n    (reset_n),
    .start    (tmr_start),
    .load_val (tmr_load),
    .done     (tmr_done)
  );

  always_ff @(posedge clk_t or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    cmd = CMD_NOP;
    case (state)
      ST_INIT:     if (tmr_done) nxt = ST_IDLE;
      ST_IDLE: begin
        if (req_valid) begin
          if (hit)           nxt = ST_ACCESS;
          else if (row_open) nxt = ST_PRE;
          else               nxt = ST_ACT;
        end
      end
      ST_PRE: begin
        cmd = CMD_PRE;
        nxt = ST_PRE_WAIT;
      end
      ST_PRE_WAIT: if (tmr_done) nxt = ST_ACT;
      ST_ACT: begin
        cmd = CMD_ACT;
        nxt = ST_RCD_WAIT;
      end
      ST_RCD_WAIT: if (tmr_done) nxt = ST_ACCESS;
      ST_ACCESS: begin
        cmd = rwb_q ? CMD_WR : CMD_RD;
        nxt = rwb_q ? ST_IDLE : ST_RD_WAIT;
      end
      ST_RD_WAIT:  if (tmr_done) nxt = ST_IDLE;
      default:     nxt = ST_INIT;
    endcase
  end

  // The timer is loaded on the edge that enters a wait state.
  always_comb begin
    tmr_start = 1'b0;
    tmr_load  = '0;
    if (nxt != state) begin
      case (nxt)
        ST_PRE_WAIT: begin tmr_start = 1'b1; tmr_load = RP_LD;  end
        ST_RCD_WAIT: begin tmr_start = 1'b1; tmr_load = RCD_LD; end
        ST_RD_WAIT:  begin tmr_start = 1'b1; tmr_load = CL_LD;  end
        default:     tmr_start = 1'b0;
      endcase
    end
  end

  always_comb begin
    pins        = encode_cmd(cmd, CLOSED_PAGE);
    act         = pins.act;
    cs          = pins.cs;
    ras         = pins.ras;
    cas         = pins.cas;
    rwb         = pins.rwb;
    auto_pre    = pins.auto_pre;
    bank_grp    = 1'b0;
    bank_no     = '0;
    row_address = '0;
    col_address = '0;
    dq_out      = '0;
    case (cmd)
      CMD_ACT: begin
        bank_grp    = req_q.bank_grp;
        bank_no     = req_q.bank_no;
        row_address = req_q.row;
      end
      CMD_PRE: begin
        bank_grp    = open_q.bank_grp;
        bank_no     = open_q.bank_no;
        row_address = open_q.row;
      end
      CMD_WR: begin
        col_address = req_q.col;
        dq_out      = wdata_q;
      end
      CMD_RD:  col_address = req_q.col;
      default: col_address = '0;
    endcase
  end

  always_ff @(posedge clk_t or negedge reset_n) begin
    if (!reset_n) begin
      req_q     <= '0;
      rwb_q     <= 1'b0;
      wdata_q   <= '0;
      row_open  <= 1'b0;
      open_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      cke       <= 1'b0;
    end else begin
      cke       <= 1'b1;
      rsp_valid <= 1'b0;
      if (accept) begin
        req_q   <= a_in;
        rwb_q   <= req_rwb;
        wdata_q <= req_wdata;
      end
      case (state)
        ST_ACT: begin
          row_open <= 1'b1;
          open_q   <= {req_q.bank_grp, req_q.bank_no, req_q.row};
        end
        ST_PRE:     row_open <= 1'b0;
        // With auto-precharge the device closes the row itself.
        ST_ACCESS:  if (CLOSED_PAGE) row_open <= 1'b0;
        ST_RD_WAIT: begin
          if (tmr_done) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= dq_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_cmd_initiator.sv
// Directed bench for ddr_cmd_initiator: open-page instance plus a closed-page instance,
// each driving a small behavioural bank model; commands and read data go through queues.
module tb_ddr_cmd_initiator;

  localparam int K_ACT = 0;
  localparam int K_WR  = 1;
  localparam int K_RD  = 2;
  localparam int K_PRE = 3;

  logic clk_t = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_t = ~clk_t;

  // open-page instance
  logic        rv1 = 1'b0, rw1 = 1'b0;
  logic [8:0]  ra1 = '0;
  logic [15:0] wd1 = '0;
  logic        rr1, rsv1, cke1, cs1, act1, ras1, cas1, rwb1, ap1, bg1;
  logic [15:0] rd1, dqo1;
  logic [15:0] dqi1 = '0;
  logic [1:0]  bn1;
  logic [2:0]  row1, col1;

  // closed-page instance
  logic        rv2 = 1'b0, rw2 = 1'b0;
  logic [8:0]  ra2 = '0;
  logic [15:0] wd2 = '0;
  logic        rr2, rsv2, cke2, cs2, act2, ras2, cas2, rwb2, ap2, bg2;
  logic [15:0] rd2, dqo2;
  logic [15:0] dqi2 = '0;
  logic [1:0]  bn2;
  logic [2:0]  row2, col2;

  ddr_cmd_initiator dut (
    .clk_t(clk_t), .reset_n(reset_n), .req_valid(rv1), .req_ready(rr1), .req_rwb(rw1),
    .req_addr(ra1), .req_wdata(wd1), .rsp_valid(rsv1), .rsp_rdata(rd1), .cke(cke1),
    .cs(cs1), .act(act1), .ras(ras1), .cas(cas1), .rwb(rwb1), .auto_pre(ap1),
    .bank_grp(bg1), .bank_no(bn1), .row_address(row1), .col_address(col1),
    .dq_out(dqo1), .dq_in(dqi1)
  );

  ddr_cmd_initiator #(.OPEN_PAGE(0)) dut_cp (
    .clk_t(clk_t), .reset_n(reset_n), .req_valid(rv2), .req_ready(rr2), .req_rwb(rw2),
    .req_addr(ra2), .req_wdata(wd2), .rsp_valid(rsv2), .rsp_rdata(rd2), .cke(cke2),
    .cs(cs2), .act(act2), .ras(ras2), .cas(cas2), .rwb(rwb2), .auto_pre(ap2),
    .bank_grp(bg2), .bank_no(bn2), .row_address(row2), .col_address(col2),
    .dq_out(dqo2), .dq_in(dqi2)
  );

  logic [30:0] pins1, pins2;
  assign pins1 = {act1, cs1, ras1, cas1, rwb1, ap1, bg1, bn1, row1, col1, dqo1};
  assign pins2 = {act2, cs2, ras2, cas2, rwb2, ap2, bg2, bn2, row2, col2, dqo2};

  // Bank model for the open-page instance: unwritten cells read as 0x1000+addr.
  logic [5:0]  m1_row = '0;
  logic [15:0] m1_mem [512];
  bit          m1_wr  [512];
  always @(posedge clk_t) begin
    if (act1 && ras1 && !cs1) m1_row <= {bg1, bn1, row1};
    if (act1 && cs1 && cas1 && rwb1) begin
      m1_mem[{m1_row, col1}] <= dqo1;
      m1_wr[{m1_row, col1}]  <= 1'b1;
    end
    if (act1 && cs1 && cas1 && !rwb1)
      dqi1 <= m1_wr[{m1_row, col1}] ? m1_mem[{m1_row, col1}] : 16'h1000 + 16'({m1_row, col1});
  end

  // Bank model for the closed-page instance: reads return 0xC000 | address.
  logic [5:0] m2_row = '0;
  always @(posedge clk_t) begin
    if (act2 && ras2 && !cs2) m2_row <= {bg2, bn2, row2};
    if (act2 && cs2 && cas2 && !rwb2) dqi2 <= 16'hC000 | {7'h0, m2_row, col2};
  end

  int          checks = 0;
  int          failures = 0;
  logic [30:0] cmdq[$];
  logic [15:0] rdq[$];
  logic [15:0] exp_mem [512];
  bit          tb_open = 1'b0;
  logic [5:0]  tb_row = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] ec(input int k, input logic [5:0] r6, input logic [2:0] col,
                                     input logic [15:0] dq, input logic ap);
    case (k)
      K_ACT:   return {6'b101000, r6, 3'b000, 16'h0000};
      K_WR:    return {5'b11011, ap, 6'b000000, col, dq};
      K_RD:    return {5'b11010, ap, 6'b000000, col, 16'h0000};
      default: return {6'b000001, r6, 3'b000, 16'h0000};
    endcase
  endfunction

  // Open-page reference: push the commands and read data a request should produce.
  task automatic expect_req(input logic w, input logic [8:0] a, input logic [15:0] d);
    if (!(tb_open && tb_row == a[8:3])) begin
      if (tb_open) cmdq.push_back(ec(K_PRE, tb_row, 3'd0, 16'h0, 1'b0));
      cmdq.push_back(ec(K_ACT, a[8:3], 3'd0, 16'h0, 1'b0));
      tb_open = 1'b1;
      tb_row  = a[8:3];
    end
    if (w) begin
      cmdq.push_back(ec(K_WR, 6'd0, a[2:0], d, 1'b0));
      exp_mem[a] = d;
    end else begin
      cmdq.push_back(ec(K_RD, 6'd0, a[2:0], 16'h0, 1'b0));
      rdq.push_back(exp_mem[a]);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send(input bit sel, input logic w, input logic [8:0] a, input logic [15:0] d);
    if (!sel) begin
      chk("ready_before_req", {31'h0, rr1}, 32'h1);
      rv1 = 1'b1; rw1 = w; ra1 = a; wd1 = d;
      @(negedge clk_t);
      rv1 = 1'b0; rw1 = ~w; ra1 = ~a; wd1 = ~d;
    end else begin
      chk("ready_before_req_cp", {31'h0, rr2}, 32'h1);
      rv2 = 1'b1; rw2 = w; ra2 = a; wd2 = d;
      @(negedge clk_t);
      rv2 = 1'b0; rw2 = ~w; ra2 = ~a; wd2 = ~d;
    end
  endtask

  // Compare every non-NOP command and response against the queues until drained and idle.
  task automatic mon(input bit sel, input int budget, input string tag, output int lat);
    logic [30:0] p;
    logic [15:0] rd;
    logic        rv, rdy;
    bit          done_f;
    done_f = 1'b0;
    lat = -1;
    for (int t = 1; t <= budget && !done_f; t++) begin
      p   = sel ? pins2 : pins1;
      rv  = sel ? rsv2 : rsv1;
      rd  = sel ? rd2 : rd1;
      rdy = sel ? rr2 : rr1;
      if (p[30:25] != 6'b0) begin
        if (cmdq.size() == 0) chk({tag, "_unexpected_cmd"}, {1'b0, p}, 32'h0);
        else                  chk({tag, "_cmd"}, {1'b0, p}, {1'b0, cmdq.pop_front()});
      end
      if (rv) begin
        lat = t;
        if (rdq.size() == 0) chk({tag, "_unexpected_rsp"}, {16'h0, rd}, 32'hFFFF_FFFF);
        else                 chk({tag, "_rdata"}, {16'h0, rd}, {16'h0, rdq.pop_front()});
      end
      if (rdy && cmdq.size() == 0 && rdq.size() == 0) done_f = 1'b1;
      else @(negedge clk_t);
    end
    checks++;
    assert (done_f) else begin
      failures++;
      $error("FAIL %s_timeout observed=%0d_pending expected=0_pending", tag, cmdq.size() + rdq.size());
    end
    cmdq.delete();
    rdq.delete();
  endtask

  // Four INIT cycles after release: cke up at once, no commands, ready only on the fourth.
  task automatic init_check(input string tag);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_t);
      if (i == 1) chk({tag, "_cke"}, {31'h0, cke1}, 32'h1);
      chk({tag, "_quiet_pins"}, {1'b0, pins1}, 32'h0);
      chk({tag, "_ready"}, {31'h0, rr1}, (i == 4) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [8:0]  a;
    logic [15:0] d;
    logic        w;
    for (int i = 0; i < 512; i++) exp_mem[i] = 16'h1000 + 16'(i);

    #2;
    chk("rst_ready", {31'h0, rr1}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsv1}, 32'h0);
    chk("rst_rdata", {16'h0, rd1}, 32'h0);
    chk("rst_cke", {31'h0, cke1}, 32'h0);
    chk("rst_pins", {1'b0, pins1}, 32'h0);
    chk("rst_pins_cp", {1'b0, pins2}, 32'h0);
    @(negedge clk_t);
    @(negedge clk_t);
    reset_n = 1'b1;
    init_check("init");

    // write from closed state, then hit read of the same cell
    a = {1'b0, 2'd2, 3'd3, 3'd5};
    expect_req(1'b1, a, 16'hA5A5);
    send(1'b0, 1'b1, a, 16'hA5A5);
    mon(1'b0, 20, "wr_closed", lat);
    expect_req(1'b0, a, 16'h0);
    send(1'b0, 1'b0, a, 16'h0);
    mon(1'b0, 20, "rd_hit", lat);
    chk("rd_hit_latency", lat, 32'd3);

    // row miss: PRE old row, ACT new row, RD
    a = {1'b1, 2'd0, 3'd6, 3'd1};
    expect_req(1'b0, a, 16'h0);
    send(1'b0, 1'b0, a, 16'h0);
    mon(1'b0, 20, "rd_miss", lat);

    a = {1'b1, 2'd0, 3'd6, 3'd7};
    expect_req(1'b1, a, 16'h3C5A);
    send(1'b0, 1'b1, a, 16'h3C5A);
    mon(1'b0, 20, "wr_hit", lat);
    expect_req(1'b0, a, 16'h0);
    send(1'b0, 1'b0, a, 16'h0);
    mon(1'b0, 20, "rd_after_wr", lat);

    // mixed traffic, every other request forced onto the open row
    for (int i = 0; i < 8; i++) begin
      a = 9'($urandom_range(0, 511));
      if (i % 2 == 0) a[8:3] = tb_row;
      w = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      expect_req(w, a, d);
      send(1'b0, w, a, d);
      mon(1'b0, 30, "mixed", lat);
    end

    // reset during RCD_WAIT of a miss sequence
    a = {tb_row ^ 6'b000001, 3'd2};
    send(1'b0, 1'b0, a, 16'h0);
    chk("rstmid_pre", {1'b0, pins1}, {1'b0, ec(K_PRE, tb_row, 3'd0, 16'h0, 1'b0)});
    @(negedge clk_t);
    @(negedge clk_t);
    chk("rstmid_act", {1'b0, pins1}, {1'b0, ec(K_ACT, a[8:3], 3'd0, 16'h0, 1'b0)});
    @(negedge clk_t);
    reset_n = 1'b0;
    #1;
    chk("rstmid_pins", {1'b0, pins1}, 32'h0);
    chk("rstmid_cke", {31'h0, cke1}, 32'h0);
    chk("rstmid_ready", {31'h0, rr1}, 32'h0);
    chk("rstmid_rsp_valid", {31'h0, rsv1}, 32'h0);
    @(negedge clk_t);
    chk("rstmid_rsp_valid_hold", {31'h0, rsv1}, 32'h0);
    reset_n = 1'b1;
    tb_open = 1'b0;
    init_check("reinit");

    // tracker cleared: a former open row must be activated again
    a = {1'b1, 2'd0, 3'd6, 3'd0};
    expect_req(1'b0, a, 16'h0);
    send(1'b0, 1'b0, a, 16'h0);
    mon(1'b0, 20, "rd_after_reset", lat);
    chk("rd_closed_latency", lat, 32'd5);

    // closed page: both reads activate, RD carries auto_pre, no PRE
    a = {1'b0, 2'd1, 3'd2, 3'd3};
    for (int i = 0; i < 2; i++) begin
      cmdq.push_back(ec(K_ACT, a[8:3], 3'd0, 16'h0, 1'b0));
      cmdq.push_back(ec(K_RD, 6'd0, a[2:0], 16'h0, 1'b1));
      rdq.push_back(16'hC000 | {7'h0, a});
      send(1'b1, 1'b0, a, 16'h0);
      mon(1'b1, 20, "cp_rd", lat);
      chk("cp_rd_latency", lat, 32'd5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
